ascon_permutation: RTL
======================

Name: ascon_permutation

Overview:
Iterative Ascon-p[n] permutation core for the Ascon-AEAD128 datapath. It executes one round per clock on the shared 320-bit ascon_state. It is the stage directly downstream of the mode FSM (idle/startup/initialisation/…/output_end): the FSM hands it a state and a round count, waits for done, then consumes the permuted state. The number of rounds is selected per call, so the same core serves p12 (initialisation/finalisation) and p8 (associated data and plaintext/ciphertext blocks).

Parameters:
- none: widths are fixed by ascon_state (5x64) and the round type (4 bits).

Ports:
- clk       input   1    system clock, rising edge
- rst       input   1    synchronous, active-high reset
- start_i   input   1    request a permutation; accepted only while busy_o=0
- rounds_i  input   4    (round type) number of rounds n, range 0..15; sampled with an accepted start
- state_i   input   320  (ascon_state) input state; sampled with an accepted start
- busy_o    output  1    high from the cycle after acceptance until the last round completes
- done_o    output  1    one-cycle pulse: state_o holds the permuted result
- state_o   output  320  (ascon_state) working/result register; held stable while idle

Behaviour:
- Reset (synchronous, any cycle, including mid-permutation): FSM->IDLE, state_o=0, busy_o=0, done_o=0, round counter=0. A start_i in the reset cycle is ignored.
- FSM states: IDLE and RUN.
- IDLE, start_i=1:
  - Register state_i into state_o.
  - Latch n=rounds_i and clear the counter.
  - Go to RUN if n>0. If n=0, stay in IDLE and pulse done_o next cycle with state_o=state_i.
- RUN, each edge:
  - state_o <= round(state_o, c) with c = const_add[(cnt - n) mod 16], computed in 4-bit wrap arithmetic, i.e. index 16-n+cnt.
  - cnt++.
  - When cnt==n-1, go to IDLE and set done_o=1 for the following cycle.
- Constant indexing: p12 uses indices 4..15 (0xF0..0x4B); p8 uses indices 8..15 (0xB4..0x4B).
- Latency: start accepted at edge T. done_o is high during the cycle after edge T+n, so latency is n+1 cycles. Throughput is one permutation per n+1 cycles.
- busy_o=1 exactly while in RUN. done_o and busy_o are never high together.
- start_i while busy_o=1: ignored; no effect on state, counter or n.
- start_i in the done_o cycle: accepted, since the core is IDLE. state_o is overwritten at that edge, so the consumer must capture the result in the done_o cycle.
- state_o is not modified in IDLE except on an accepted start.
- Round function (combinational), in order:
  - pC: s2 ^= {56'b0, c}.
  - pS: for each bit j in 0..63, x = {s0[j],s1[j],s2[j],s3[j],s4[j]} with s0 as MSB. Apply y = s_box[x] and write back with the same bit order.
  - pL (rotations are right-rotates by the listed amounts):
    - s0 ^= ror(s0,19) ^ ror(s0,28)
    - s1 ^= ror(s1,61) ^ ror(s1,39)
    - s2 ^= ror(s2,1) ^ ror(s2,6)
    - s3 ^= ror(s3,10) ^ ror(s3,17)
    - s4 ^= ror(s4,7) ^ ror(s4,41)
- All outputs are registered. There is no combinational path from inputs to outputs.

Decomposition:
- Shared package additions:
  - permutation FSM enum (perm_idle, perm_run);
  - constants ROUNDS_A=4'd12 and ROUNDS_B=4'd8;
  - a function giving the round-constant index from (cnt, n).
- The existing const_add, s_box, ascon_state and round types are reused, not redefined.
- One sub-module, ascon_round: purely combinational. Inputs are ascon_state and an 8-bit constant; output is ascon_state. It is instantiated once in this core and is reusable by an unrolled variant later.

Test Plan:
- Zero state, n=1: start with state_i=0, rounds_i=1.
  - done_o rises 2 cycles after start.
  - state_o.s2 = 64'h53FFFFFFFFFFFF90 and state_o.s4 = 0; all fields must match the golden model.
- Ascon-AEAD128 initialisation: IV||K||N state with n=12.
  - done_o 13 cycles after start; busy_o high for exactly 12 cycles.
  - Result matches the reference C model.
- n=8 on a random state, then an immediate back-to-back start in the done_o cycle with n=12.
  - Both results are correct.
  - The second done_o comes 13 cycles after the first.
- Start pulses every cycle while busy, with changing state_i/rounds_i: all are ignored; the result equals a single n=12 run of the first accepted input.
- n=0: done_o the cycle after start; state_o equals state_i; busy_o never asserts.
- rst asserted at round 5 of a p12 run: the next cycle shows state_o=0, busy_o=0, done_o=0, and no done_o pulse follows. A fresh start then completes normally.

Source files
------------

// File: rtl/ascon_permutation_pkg.sv
// rtl/ascon_permutation_pkg.sv - shared Ascon types, tables and permutation helpers
//
// Purpose: common definitions for the Ascon-AEAD128 datapath.
//   ascon_state_t      five 64-bit words, s0 in the most significant position
//   ascon_round_t      4-bit round count / round-constant index
//   perm_fsm_t         permutation core states
//   CONST_ADD, S_BOX   round constants and 5-bit substitution table
//   round_const_index  constant index for round cnt of an n-round call
//   ror64              64-bit right rotate
package ascon_permutation_pkg;

    typedef logic [63:0] ascon_word_t;

    typedef struct packed {
        ascon_word_t s0;
        ascon_word_t s1;
        ascon_word_t s2;
        ascon_word_t s3;
        ascon_word_t s4;
    } ascon_state_t;

    typedef logic [3:0] ascon_round_t;

    typedef enum logic [0:0] {
        perm_idle = 1'b0,
        perm_run  = 1'b1
    } perm_fsm_t;

    localparam ascon_round_t ROUNDS_A = 4'd12;
    localparam ascon_round_t ROUNDS_B = 4'd8;

    // Sixteen-entry constant table; an n-round call uses the last n entries.
    localparam logic [7:0] CONST_ADD [16] = '{
        8'h3c, 8'h2d, 8'h1e, 8'h0f, 8'hf0, 8'he1, 8'hd2, 8'hc3,
        8'hb4, 8'ha5, 8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b
    };

    localparam logic [4:0] S_BOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    // 4-bit wrap gives 16 - n + cnt, i.e. the tail of the constant table.
    function automatic ascon_round_t round_const_index(input ascon_round_t cnt,
                                                       input ascon_round_t n);
        return cnt - n;
    endfunction

    function automatic ascon_word_t ror64(input ascon_word_t x, input int unsigned amt);
        return (x >> amt) | (x << (64 - amt));
    endfunction

endpackage

// File: rtl/ascon_round.sv
// rtl/ascon_round.sv - one combinational Ascon round (constant add, S-box layer, linear layer)
//
// Ports:
//   state_in   input state
//   rc         8-bit round constant, xored into the low byte of s2
//   state_out  state after one full round
module ascon_round
    import ascon_permutation_pkg::*;
(
    input  ascon_state_t state_in,
    input  logic [7:0]   rc,
    output ascon_state_t state_out
);

    ascon_state_t added;
    ascon_state_t subst;
    logic [4:0]   col_in;
    logic [4:0]   col_out;

    always_comb begin
        added    = state_in;
        added.s2 = state_in.s2 ^ {56'b0, rc};

        subst   = added;
        col_in  = '0;
        col_out = '0;
        // Each bit column across the five words is one 5-bit S-box input, s0 as MSB.
        for (int j = 0; j < 64; j++) begin
            col_in      = {added.s0[j], added.s1[j], added.s2[j], added.s3[j], added.s4[j]};
            col_out     = S_BOX[col_in];
            subst.s0[j] = col_out[4];
            subst.s1[j] = col_out[3];
            subst.s2[j] = col_out[2];
            subst.s3[j] = col_out[1];
            subst.s4[j] = col_out[0];
        end

        state_out.s0 = subst.s0 ^ ror64(subst.s0, 19) ^ ror64(subst.s0, 28);
        state_out.s1 = subst.s1 ^ ror64(subst.s1, 61) ^ ror64(subst.s1, 39);
        state_out.s2 = subst.s2 ^ ror64(subst.s2, 1)  ^ ror64(subst.s2, 6);
        state_out.s3 = subst.s3 ^ ror64(subst.s3, 10) ^ ror64(subst.s3, 17);
        state_out.s4 = subst.s4 ^ ror64(subst.s4, 7)  ^ ror64(subst.s4, 41);
    end

endmodule

// File: rtl/ascon_permutation.sv
// rtl/ascon_permutation.sv - iterative Ascon-p[n] core, one round per clock
//
// Ports:
//   clk, rst   rising-edge clock, synchronous active-high reset
//   start_i    request a permutation, accepted only while idle
//   rounds_i   round count n (0..15), sampled with an accepted start
//   state_i    input state, sampled with an accepted start
//   busy_o     high while rounds are being applied
//   done_o     one-cycle pulse, state_o holds the result
//   state_o    working/result register, stable while idle
module ascon_permutation
    import ascon_permutation_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  ascon_round_t rounds_i,
    input  ascon_state_t state_i,
    output logic         busy_o,
    output logic         done_o,
    output ascon_state_t state_o
);

    perm_fsm_t    fsm;
    ascon_round_t cnt;
    ascon_round_t n_rounds;
    ascon_state_t round_out;
    logic [7:0]   rc;

    assign rc = CONST_ADD[round_const_index(cnt, n_rounds)];

    ascon_round u_round (
        .state_in  (state_o),
        .rc        (rc),
        .state_out (round_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm      <= perm_idle;
            state_o  <= '0;
            done_o   <= 1'b0;
            cnt      <= '0;
            n_rounds <= '0;
        end else begin
            done_o <= 1'b0;
            case (fsm)
                perm_idle: begin
                    if (start_i) begin
                        state_o  <= state_i;
                        n_rounds <= rounds_i;
                        cnt      <= '0;
                        // A zero-round call returns the input unchanged one cycle later.
                        if (rounds_i == 4'd0) begin
                            done_o <= 1'b1;
                        end else begin
                            fsm <= perm_run;
                        end
                    end
                end
                perm_run: begin
                    state_o <= round_out;
                    cnt     <= cnt + 4'd1;
                    if (cnt == n_rounds - 4'd1) begin
                        fsm    <= perm_idle;
                        done_o <= 1'b1;
                    end
                end
                default: fsm <= perm_idle;
            endcase
        end
    end

    assign busy_o = (fsm == perm_run);

endmodule
